// File: rtl/mem_arbiter.sv
// Single-port SRAM controller shared by instruction fetch and the MEM stage.
// Fixed-priority arbiter (MEM over IF) feeding a small read/write sequencer.
// All SRAM strobes, read data and done pulses are registered; only the
// stall request is combinational so the pipeline freezes in the same cycle.
module mem_arbiter #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_done_o,
    output logic              stallreq_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    output logic              sram_data_oe_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);

    localparam int MAXW  = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t           state;
    logic             owner_mem;
    logic [CNT_W-1:0] wait_cnt;

    // A requester whose done pulse is high this cycle is still holding its
    // level request; masking it here prevents serving it a second time.
    logic mem_wr_ok;
    logic mem_rd_ok;
    logic if_ok;

    assign mem_wr_ok = mem_wr_i & ~mem_done_o;
    assign mem_rd_ok = mem_rd_i & ~mem_done_o;
    assign if_ok     = if_req_i & ~if_done_o;

    // Stall is raised the moment a MEM request appears and dropped in its done cycle.
    assign stallreq_o = (mem_rd_i | mem_wr_i) & ~mem_done_o;

    // Arbitration and SRAM sequencing FSM with registered strobes and results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            owner_mem      <= 1'b0;
            wait_cnt       <= '0;
            sram_addr_o    <= '0;
            sram_wdata_o   <= '0;
            sram_data_oe_o <= 1'b0;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            if_rdata_o     <= '0;
            mem_rdata_o    <= '0;
            if_done_o      <= 1'b0;
            mem_done_o     <= 1'b0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (mem_wr_ok) begin
                        owner_mem      <= 1'b1;
                        sram_addr_o    <= mem_addr_i;
                        sram_wdata_o   <= mem_wdata_i;
                        sram_data_oe_o <= 1'b1;
                        state          <= WR_SETUP;
                    end else if (mem_rd_ok) begin
                        owner_mem   <= 1'b1;
                        sram_addr_o <= mem_addr_i;
                        sram_oe_n_o <= 1'b0;
                        state       <= READ;
                    end else if (if_ok) begin
                        owner_mem   <= 1'b0;
                        sram_addr_o <= if_addr_i;
                        sram_oe_n_o <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (wait_cnt == RD_LAST) begin
                        wait_cnt    <= '0;
                        sram_oe_n_o <= 1'b1;
                        state       <= IDLE;
                        if (owner_mem) begin
                            mem_rdata_o <= sram_rdata_i;
                            mem_done_o  <= 1'b1;
                        end else begin
                            if_rdata_o <= sram_rdata_i;
                            if_done_o  <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WR_SETUP: begin
                    sram_we_n_o <= 1'b0;
                    state       <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (wait_cnt == WR_LAST) begin
                        wait_cnt    <= '0;
                        sram_we_n_o <= 1'b1;
                        state       <= WR_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WR_HOLD: begin
                    sram_data_oe_o <= 1'b0;
                    mem_done_o     <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    wait_cnt       <= '0;
                    sram_data_oe_o <= 1'b0;
                    sram_oe_n_o    <= 1'b1;
                    sram_we_n_o    <= 1'b1;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port SRAM access controller and arbiter shared by instruction fetch (IF) and the MEM stage.
- Grants one requester at a time and sequences SRAM read/write timing through a small FSM.
- Returns read data with a one-cycle done pulse.
- Raises a stall request to the pipeline stall controller while the MEM-stage access is outstanding. This freezes the ex_mem register and upstream stages.

Parameters:
- ADDR_W, 18, SRAM/memory address width.
- DATA_W, 16, data word width.
- RD_WAIT, 1, cycles oe_n is held low before read data is sampled (≥1).
- WR_WAIT, 1, cycles we_n is held low per write (≥1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  IF fetch request, level, held until if_done_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetched instruction word.
- if_done_o  out  1  one-cycle pulse: if_rdata_o valid.
- mem_rd_i  in  1  MEM-stage read request, level.
- mem_wr_i  in  1  MEM-stage write request, level.
- mem_addr_i  in  ADDR_W  MEM-stage address.
- mem_wdata_i  in  DATA_W  MEM-stage write data.
- mem_rdata_o  out  DATA_W  MEM-stage read data.
- mem_done_o  out  1  one-cycle pulse: MEM access complete.
- stallreq_o  out  1  stall request to stall controller.
- sram_addr_o  out  ADDR_W  SRAM address.
- sram_wdata_o  out  DATA_W  SRAM write data.
- sram_data_oe_o  out  1  1 = drive SRAM data bus.
- sram_rdata_i  in  DATA_W  SRAM read data.
- sram_oe_n_o  out  1  SRAM output enable, active-low.
- sram_we_n_o  out  1  SRAM write enable, active-low.

Behaviour:

Reset (asynchronous, rst=0):
- FSM returns to IDLE immediately, including mid-access.
- sram_oe_n_o=1, sram_we_n_o=1, sram_data_oe_o=0.
- sram_addr_o=0, sram_wdata_o=0.
- if_rdata_o=0, mem_rdata_o=0.
- if_done_o=0, mem_done_o=0.
- owner=IF, wait counter=0.
- stallreq_o follows its combinational equation below.

FSM states: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD.

IDLE arbitration (fixed priority, MEM > IF):
- mem_wr_i → owner=MEM, latch addr/wdata, go WR_SETUP.
- else mem_rd_i → owner=MEM, latch addr, go READ.
- else if_req_i → owner=IF, latch if_addr_i, go READ.
- mem_rd_i and mem_wr_i both high: write wins, no read performed.
- In the cycle a done pulse is high, the requester just served is masked from arbitration. This avoids a re-grant on a still-high level request. The other requester may be granted in that same cycle.

READ:
- oe_n=0; counter runs RD_WAIT cycles.
- On the last READ cycle's closing edge: sample sram_rdata_i into the owner's rdata register, assert the owner's done for the next cycle, go IDLE.
- Read latency from request seen in IDLE to done = RD_WAIT+1 cycles.

WR_SETUP:
- Addr and data driven, data_oe=1, we_n=1.
- Lasts 1 cycle, then go WR_PULSE.

WR_PULSE:
- we_n=0 for WR_WAIT cycles, then go WR_HOLD.

WR_HOLD:
- we_n=1, data_oe=1 held for 1 cycle.
- Then go IDLE with mem_done_o=1.
- Write latency = WR_WAIT+3 cycles.

Output timing and invariants:
- oe_n and we_n are never both low.
- data_oe=0 whenever oe_n=0.
- Done pulses last exactly one cycle. At most one of if_done_o or mem_done_o is high in any cycle.
- rdata registers hold their value until the next read for the same owner.

Stall and addressing:
- stallreq_o = (mem_rd_i | mem_wr_i) & ~mem_done_o. This is combinational, so the pipeline freezes the same cycle the request appears.
- IF waits are signalled only by the absence of if_done_o.
- Addresses are passed through unchanged; there is no wrap or range check.
- Inputs are latched at grant, so input changes mid-access are ignored.

Test Plan:
1. RD_WAIT=1. if_req_i=1, if_addr_i=0x00040, SRAM returns 0x4E21 → sram_oe_n_o low in cycle 1, if_done_o=1 with if_rdata_o=0x4E21 in cycle 2, stallreq_o stays 0.
2. WR_WAIT=1. mem_wr_i=1, addr 0x08000, wdata 0xBEEF:
   - we_n sequence 1,0,1 over cycles 1–3, data_oe=1 throughout cycles 1–3.
   - mem_done_o in cycle 4.
   - stallreq_o=1 in cycles 0–3 and 0 in cycle 4.
3. if_req_i and mem_rd_i asserted in the same cycle → MEM served first (mem_done_o at cycle 2). IF is granted in the mem_done_o cycle and if_done_o pulses at cycle 4, with no double-grant to MEM.
4. mem_rd_i=mem_wr_i=1 → only the write sequence occurs, oe_n remains 1 throughout, one mem_done_o.
5. rst pulled low during WR_PULSE → we_n=1, data_oe=0, oe_n=1 immediately without a clock edge. After release, FSM is in IDLE and no done pulse occurs for the aborted access.
6. RD_WAIT=3, continuous if_req_i held after done → oe_n low exactly 3 cycles per read. The done cycle masks the re-grant, so reads repeat with a 5-cycle period (IDLE mask, IDLE grant, 3 READ).
